// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for a 64-bit ARMv8-style core, with the ALU control
// decoder in front of the register and the EX-stage operand forwarding muxes
// behind it.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (forces a bubble)
//   stall, flush        hold the stage / load a bubble (flush wins)
//   in_valid            decode-stage instruction valid
//   rd1, rd2, imm       register-file read data and sign-extended immediate
//   rn, rm, rd          source and destination register numbers
//   alu_src, alu_op     operand B select (1 = imm), main-decoder ALU class
//   opcode              instruction[31:21]
//   reg_write .. branch decode control bits
//   exmem_*, memwb_*    later-stage writeback info used for forwarding
//   ex_valid            EX stage holds a real instruction
//   alu_a, alu_b        forwarded ALU operands
//   alu_ctl             ALU operation code
//   ex_store_data       forwarded Rm value for stores
//   ex_rd               destination register
//   ex_reg_write .. ex_branch  registered control bits
//   ex_illegal          unrecognised R-type opcode
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   input  logic [DATA_W-1:0] imm,
   input  logic [4:0]        rn,
   input  logic [4:0]        rm,
   input  logic [4:0]        rd,
   input  logic              alu_src,
   input  logic [1:0]        alu_op,
   input  logic [10:0]       opcode,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_to_reg,
   input  logic              branch,
   input  logic              exmem_reg_write,
   input  logic [4:0]        exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [4:0]        memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_ctl,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [4:0]        ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_branch,
   output logic              ex_illegal
);

   localparam logic [3:0]  CTL_AND   = 4'b0000;
   localparam logic [3:0]  CTL_ORR   = 4'b0001;
   localparam logic [3:0]  CTL_ADD   = 4'b0010;
   localparam logic [3:0]  CTL_SUB   = 4'b0110;
   localparam logic [3:0]  CTL_PASSB = 4'b0111;
   localparam logic [3:0]  CTL_NOR   = 4'b1100;
   localparam logic [4:0]  XZR       = 5'd31;
   localparam logic [10:0] OPC_ADD   = 11'b10001011000;
   localparam logic [10:0] OPC_SUB   = 11'b11001011000;
   localparam logic [10:0] OPC_AND   = 11'b10001010000;
   localparam logic [10:0] OPC_ORR   = 11'b10101010000;

   // Returns {illegal, alu_ctl}. Unknown R-type opcodes fall back to ADD so the
   // datapath stays well-defined while the illegal flag reports the problem.
   function automatic logic [4:0] alu_decode(input logic [1:0] op, input logic [10:0] opc);
      logic [4:0] res;
      res = {1'b0, CTL_ADD};
      unique case (op)
         2'b00: res = {1'b0, CTL_ADD};
         2'b01: res = {1'b0, CTL_PASSB};
         2'b11: res = {1'b0, CTL_NOR};
         2'b10: begin
            unique case (opc)
               OPC_ADD: res = {1'b0, CTL_ADD};
               OPC_SUB: res = {1'b0, CTL_SUB};
               OPC_AND: res = {1'b0, CTL_AND};
               OPC_ORR: res = {1'b0, CTL_ORR};
               default: res = {1'b1, CTL_ADD};
            endcase
         end
         default: res = {1'b0, CTL_ADD};
      endcase
      return res;
   endfunction

   // EX/MEM is checked first: it holds the younger producer. XZR is never
   // forwarded because writes to it are discarded by the register file.
   function automatic logic [DATA_W-1:0] forward(input logic [4:0] src,
                                                 input logic [DATA_W-1:0] rf_val);
      logic [DATA_W-1:0] res;
      if (exmem_reg_write && (exmem_rd != XZR) && (exmem_rd == src))
         res = exmem_result;
      else if (memwb_reg_write && (memwb_rd != XZR) && (memwb_rd == src))
         res = memwb_result;
      else
         res = rf_val;
      return res;
   endfunction

   logic              valid_q,      valid_d;
   logic [DATA_W-1:0] rd1_q,        rd1_d;
   logic [DATA_W-1:0] rd2_q,        rd2_d;
   logic [DATA_W-1:0] imm_q,        imm_d;
   logic [4:0]        rn_q,         rn_d;
   logic [4:0]        rm_q,         rm_d;
   logic [4:0]        rd_q,         rd_d;
   logic              alu_src_q,    alu_src_d;
   logic [3:0]        alu_ctl_q,    alu_ctl_d;
   logic              illegal_q,    illegal_d;
   logic              reg_write_q,  reg_write_d;
   logic              mem_read_q,   mem_read_d;
   logic              mem_write_q,  mem_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              branch_q,     branch_d;

   logic [4:0]        dec;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_m;

   assign dec = alu_decode(alu_op, opcode);

   // Next-state: flush beats stall beats load.
   always_comb begin
      valid_d      = valid_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      imm_d        = imm_q;
      rn_d         = rn_q;
      rm_d         = rm_q;
      rd_d         = rd_q;
      alu_src_d    = alu_src_q;
      alu_ctl_d    = alu_ctl_q;
      illegal_d    = illegal_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      branch_d     = branch_q;
      if (flush) begin
         valid_d      = 1'b0;
         rd1_d        = '0;
         rd2_d        = '0;
         imm_d        = '0;
         rn_d         = '0;
         rm_d         = '0;
         rd_d         = '0;
         alu_src_d    = 1'b0;
         alu_ctl_d    = CTL_ADD;
         illegal_d    = 1'b0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         branch_d     = 1'b0;
      end else if (!stall) begin
         valid_d      = in_valid;
         rd1_d        = rd1;
         rd2_d        = rd2;
         imm_d        = imm;
         rn_d         = rn;
         rm_d         = rm;
         rd_d         = rd;
         alu_src_d    = alu_src;
         alu_ctl_d    = dec[3:0];
         illegal_d    = dec[4];
         reg_write_d  = reg_write  & in_valid;
         mem_read_d   = mem_read   & in_valid;
         mem_write_d  = mem_write  & in_valid;
         mem_to_reg_d = mem_to_reg & in_valid;
         branch_d     = branch     & in_valid;
      end
   end

   // ID/EX stage boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         rn_q         <= '0;
         rm_q         <= '0;
         rd_q         <= '0;
         alu_src_q    <= 1'b0;
         alu_ctl_q    <= CTL_ADD;
         illegal_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         branch_q     <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         rn_q         <= rn_d;
         rm_q         <= rm_d;
         rd_q         <= rd_d;
         alu_src_q    <= alu_src_d;
         alu_ctl_q    <= alu_ctl_d;
         illegal_q    <= illegal_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         branch_q     <= branch_d;
      end
   end

   // Forwarding is purely combinational off the registered source numbers.
   assign fwd_a = forward(rn_q, rd1_q);
   assign fwd_m = forward(rm_q, rd2_q);

   assign ex_valid      = valid_q;
   assign alu_a         = fwd_a;
   assign alu_b         = alu_src_q ? imm_q : fwd_m;
   assign alu_ctl       = alu_ctl_q;
   assign ex_store_data = fwd_m;
   assign ex_rd         = rd_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_mem_to_reg = mem_to_reg_q;
   assign ex_branch     = branch_q;
   assign ex_illegal    = illegal_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble
- in_valid  in  1  decode-stage instruction valid
- rd1, rd2  in  64  register-file read data for Rn, Rm
- imm  in  64  sign-extended immediate
- rn, rm, rd  in  5  source and destination register numbers
- alu_src  in  1  operand B select: 1 = imm, 0 = Rm
- alu_op  in  2  main-decoder ALU class
- opcode  in  11  instruction[31:21]
- reg_write, mem_read, mem_write, mem_to_reg, branch  in  1  decode control bits
- exmem_reg_write  in  1  EX/MEM write enable; exmem_rd  in  5; exmem_result  in  64
- memwb_reg_write  in  1  MEM/WB write enable; memwb_rd  in  5; memwb_result  in  64
- ex_valid  out  1  EX stage holds a real instruction
- alu_a, alu_b  out  64  ALU operands
- alu_ctl  out  4  ALU operation code
- ex_store_data  out  64  forwarded Rm value for stores
- ex_rd  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1  registered control bits
- ex_illegal  out  1  unrecognised R-type opcode

Function
REQ-003 Stage registers SHALL capture valid, rd1, rd2, imm, rn, rm, rd, alu_src, decoded alu_ctl, illegal flag and the five control bits on the rising clk edge.
REQ-004 Update priority per edge SHALL be: rst > flush > stall > load.
REQ-005 Load SHALL copy all inputs; ex_valid is in_valid, and the control bits are ANDed with in_valid.
REQ-006 Flush SHALL clear ex_valid, the five control bits and ex_illegal; data fields are zeroed; alu_ctl becomes 4'b0010.
REQ-007 Stall without flush SHALL hold every register unchanged.
REQ-008 Simultaneous flush and stall SHALL produce a bubble (flush wins).
REQ-009 ALU control SHALL be decoded before registering:
- alu_op 00 -> 0010 (add, loads and stores)
- alu_op 01 -> 0111 (pass B, CBZ)
- alu_op 11 -> 1100 (NOR)
- alu_op 10 -> by opcode: 10001011000 -> 0010 ADD; 11001011000 -> 0110 SUB; 10001010000 -> 0000 AND; 10101010000 -> 0001 ORR
- Any other alu_op 10 opcode -> 0010 and illegal = 1
REQ-010 Forwarding SHALL be combinational from the registered rn/rm and the current EX/MEM and MEM/WB inputs; there is no extra latency.
REQ-011 The forwarded A value SHALL be selected as follows:
- exmem_result if exmem_reg_write, exmem_rd != 31 and exmem_rd == registered rn
- else memwb_result under the same test against memwb
- else registered rd1
REQ-012 The forwarded Rm value SHALL be selected by the same rule against registered rm and rd2.
REQ-013 When EX/MEM and MEM/WB both match, EX/MEM SHALL win (most recent).
REQ-014 Register 31 (XZR) SHALL never be forwarded; the register-file value passes through.
REQ-015 Outputs SHALL be driven as follows:
- alu_a = forwarded A
- alu_b = registered imm when registered alu_src = 1, else forwarded Rm
- ex_store_data = forwarded Rm regardless of alu_src
REQ-016 Forwarding SHALL operate identically whether ex_valid is 0 or 1; consumers gate on ex_valid.
REQ-017 End-to-end latency from decode inputs to EX outputs SHALL be exactly one clock.

Reset
REQ-018 Asserting rst SHALL immediately force a bubble: ex_valid 0, all control bits 0, ex_illegal 0, all data registers 0, alu_ctl 0010, ex_rd 0.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction; the first edge after rst deasserts performs a normal load.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- Load ADD (alu_op 10, opcode 10001011000, rd1 = 5, rd2 = 7, rn = 1, rm = 2, no forward match) -> next cycle alu_ctl 0010, alu_a 5, alu_b 7, ex_valid 1.
- Registered rn = 3, exmem_reg_write = 1, exmem_rd = 3, exmem_result = 0x100, memwb_rd = 3, memwb_result = 0x200 -> alu_a 0x100; drop exmem_reg_write -> alu_a 0x200.
- rm = 31, exmem_rd = 31 with write enabled, rd2 = 0 -> alu_b 0 and ex_store_data 0 (no forward).
- STUR (alu_op 00, alu_src 1, imm = 16, rm forwarded from memwb = 0xAB) -> alu_b 16, ex_store_data 0xAB, alu_ctl 0010.
- Stall and flush both high with a valid instruction pending -> ex_valid 0, ex_reg_write 0; stall alone for 3 cycles -> outputs constant.
- opcode 11111111111 with alu_op 10 -> ex_illegal 1, alu_ctl 0010; rst asserted asynchronously mid-cycle -> ex_valid and ex_illegal 0 before the next edge.
